// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pattern generator: display modes,
// colour words in {G,R,B} order, stream FSM states and the colour lookup.
package ws2812_pkg;

    localparam logic [1:0] MODE_RED   = 2'd0;
    localparam logic [1:0] MODE_GREEN = 2'd1;
    localparam logic [1:0] MODE_BLUE  = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    // Colour words are {G[7:0], R[7:0], B[7:0]}; low intensity keeps current modest.
    localparam logic [23:0] COL_RED   = 24'h000F00;
    localparam logic [23:0] COL_GREEN = 24'h0F0000;
    localparam logic [23:0] COL_BLUE  = 24'h00000F;
    localparam logic [23:0] COL_WHITE = 24'h0F0F0F;
    localparam logic [23:0] COL_OFF   = 24'h000000;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Colour of one LED given the display mode and whether it sits on the chase position.
    function automatic logic [23:0] mode_colour(input logic [1:0] m, input logic on_pos);
        logic [23:0] c;
        case (m)
            MODE_RED:   c = COL_RED;
            MODE_GREEN: c = COL_GREEN;
            MODE_BLUE:  c = COL_BLUE;
            MODE_CHASE: c = on_pos ? COL_WHITE : COL_OFF;
            default:    c = COL_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ws2812_pattern_gen_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stability
// counter. Emits a one-cycle pulse when the debounced level falls (press).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 540_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clock domain; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            key_level   <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                key_level   <= sync2;
                press_pulse <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ws2812_pattern_gen.sv
// Pixel source for the WS2812 serializer: frame timer, key-driven mode
// selection and a valid/ready stream of LED_NUM GRB words per frame.
module ws2812_pattern_gen
    import ws2812_pkg::*;
#(
    parameter int LED_NUM      = 8,
    parameter int CLK_FRE      = 27_000_000,
    parameter int FRAME_HZ     = 50,
    parameter int DEBOUNCE_CYC = 540_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic [1:0]  mode,
    output logic        frame_overrun
);

    localparam int FRAME_TICKS = CLK_FRE / FRAME_HZ;
    localparam int FC_W        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int IDX_W       = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_NUM - 1);

    logic [FC_W-1:0]  frame_cnt;
    logic             tick;
    logic             key_level;
    logic             press_pulse;
    logic [1:0]       pending_mode;
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] pos_next;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key),
        .key_level   (key_level),
        .press_pulse (press_pulse)
    );

    assign tick     = (frame_cnt == FC_LAST);
    assign idx_next = idx + IDX_W'(1);
    assign pos_next = (pos == IDX_LAST) ? '0 : pos + IDX_W'(1);

    // Free-running frame timer; tick marks its final count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    // Requested mode advances on each debounced press; applied only at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mode <= MODE_RED;
        end else if (press_pulse && !key_level) begin
            pending_mode <= pending_mode + 2'd1;
        end else begin
            pending_mode <= pending_mode;
        end
    end

    // Stream FSM: starts a frame on tick, walks the LED index under valid/ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            pos           <= '0;
            mode          <= MODE_RED;
            pix_data      <= COL_OFF;
            pix_valid     <= 1'b0;
            pix_last      <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            // A tick while busy is dropped, including one on the final handshake.
            frame_overrun <= tick && (state == STREAM);
            case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= STREAM;
                        mode      <= pending_mode;
                        idx       <= '0;
                        pix_valid <= 1'b1;
                        pix_data  <= mode_colour(pending_mode, pos == '0);
                        pix_last  <= (IDX_LAST == '0);
                    end else begin
                        pix_valid <= 1'b0;
                    end
                end
                STREAM: begin
                    if (pix_valid && pix_ready) begin
                        if (pix_last) begin
                            state     <= IDLE;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            pix_data  <= COL_OFF;
                            if (mode == MODE_CHASE) begin
                                pos <= pos_next;
                            end else begin
                                pos <= pos;
                            end
                        end else begin
                            idx      <= idx_next;
                            pix_data <= mode_colour(mode, idx_next == pos);
                            pix_last <= (idx_next == IDX_LAST);
                        end
                    end else begin
                        pix_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Directed bench for ws2812_pattern_gen: 4 LEDs, 100-cycle frames, 16-cycle debounce.
module tb_ws2812_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key = 1'b1;
    logic        pix_ready = 1'b1;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_last;
    logic [1:0]  mode;
    logic        frame_overrun;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    localparam logic [3:0][23:0] RED4   = {4{24'h000F00}};
    localparam logic [3:0][23:0] GREEN4 = {4{24'h0F0000}};
    localparam logic [3:0][23:0] BLUE4  = {4{24'h00000F}};

    ws2812_pattern_gen #(
        .LED_NUM      (4),
        .CLK_FRE      (1000),
        .FRAME_HZ     (10),
        .DEBOUNCE_CYC (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key           (key),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_last      (pix_last),
        .mode          (mode),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            ecount++;
        end
    endtask

    task automatic wait_frame(input int exp_e, input string tag);
        int budget;
        budget = 0;
        while (pix_valid !== 1'b1 && budget < 250) begin
            step(1);
            budget++;
        end
        check({tag, " start"}, 32'(pix_valid), 32'd1);
        check({tag, " start cycle"}, 32'(ecount), 32'(exp_e));
    endtask

    task automatic collect(input logic [3:0][23:0] w, input logic [1:0] m, input string tag);
        check({tag, " mode"}, 32'(mode), 32'(m));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s valid w%0d", tag, i), 32'(pix_valid), 32'd1);
            check($sformatf("%s data w%0d", tag, i), 32'(pix_data), 32'(w[i]));
            check($sformatf("%s last w%0d", tag, i), 32'(pix_last), (i == 3) ? 32'd1 : 32'd0);
            step(1);
        end
        check({tag, " idle after"}, 32'(pix_valid), 32'd0);
    endtask

    task automatic press();
        key = 1'b0;
        step(20);
        key = 1'b1;
        step(20);
    endtask

    function automatic logic [3:0][23:0] chase(input int p);
        logic [3:0][23:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i] = (i == p) ? 24'h0F0F0F : 24'h000000;
        end
        return w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][23:0] ew;
        logic [3:0]       pat;
        logic [23:0]      prev_d;
        logic             prev_l;
        logic             prev_hold;
        int               n;
        int               ov;

        // Reset state
        #2 rst_n = 1'b0;
        step(3);
        check("rst pix_valid", 32'(pix_valid), 32'd0);
        check("rst pix_data", 32'(pix_data), 32'd0);
        check("rst pix_last", 32'(pix_last), 32'd0);
        check("rst mode", 32'(mode), 32'd0);
        check("rst overrun", 32'(frame_overrun), 32'd0);
        rst_n = 1'b1;
        ecount = 0;

        // 1: first frame exactly 100 cycles after release, red words
        step(99);
        check("t1 no early valid", 32'(pix_valid), 32'd0);
        step(1);
        check("t1 first valid cycle", 32'(pix_valid), 32'd1);
        collect(RED4, 2'd0, "t1");

        // 2: glitches ignored; press during a held frame does not alter it
        key = 1'b0; step(5); key = 1'b1; step(5);
        key = 1'b0; step(5); key = 1'b1; step(5);
        pix_ready = 1'b0;
        wait_frame(200, "t2 f200");
        press();
        check("t2 held valid", 32'(pix_valid), 32'd1);
        check("t2 held data", 32'(pix_data), 32'h000F00);
        check("t2 held last", 32'(pix_last), 32'd0);
        check("t2 held mode", 32'(mode), 32'd0);
        pix_ready = 1'b1;
        collect(RED4, 2'd0, "t2 inflight");
        wait_frame(300, "t2 f300");
        collect(GREEN4, 2'd1, "t2 green");

        // 3: further presses -> blue, chase
        press();
        wait_frame(400, "t3 f400");
        collect(BLUE4, 2'd2, "t3 blue");
        press();
        wait_frame(500, "t3 f500");
        collect(chase(0), 2'd3, "t3 chase0");

        // 4: ready toggling 1,0,0,1 on chase position 1
        wait_frame(600, "t4 f600");
        check("t4 mode", 32'(mode), 32'd3);
        ew = chase(1);
        pat = 4'b1001;
        prev_hold = 1'b0;
        prev_d = 24'h0;
        prev_l = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (prev_hold) begin
                check("t4 data stable", 32'(pix_data), 32'(prev_d));
                check("t4 last stable", 32'(pix_last), 32'(prev_l));
            end
            check("t4 valid", 32'(pix_valid), 32'd1);
            pix_ready = pat[c % 4];
            if (pix_ready) begin
                check($sformatf("t4 word%0d", n), 32'(pix_data), 32'(ew[n]));
                check($sformatf("t4 last%0d", n), 32'(pix_last), (n == 3) ? 32'd1 : 32'd0);
                n++;
            end
            prev_hold = ~pix_ready;
            prev_d = pix_data;
            prev_l = pix_last;
            step(1);
        end
        pix_ready = 1'b1;
        check("t4 words delivered", 32'(n), 32'd4);
        check("t4 idle after", 32'(pix_valid), 32'd0);

        // 3 (cont.): chase advances and wraps, then fourth press back to red
        wait_frame(700, "t3 f700");
        collect(chase(2), 2'd3, "t3 chase2");
        wait_frame(800, "t3 f800");
        collect(chase(3), 2'd3, "t3 chase3");
        wait_frame(900, "t3 f900");
        collect(chase(0), 2'd3, "t3 chase wrap");
        press();
        wait_frame(1000, "t3 f1000");
        collect(RED4, 2'd0, "t3 red again");

        // 5: ready held low across a tick -> one overrun, no queued frame
        pix_ready = 1'b0;
        wait_frame(1100, "t5 f1100");
        ov = 0;
        for (int c = 0; c < 110; c++) begin
            step(1);
            if (frame_overrun === 1'b1) ov++;
        end
        check("t5 overrun pulses", 32'(ov), 32'd1);
        check("t5 held valid", 32'(pix_valid), 32'd1);
        check("t5 held data", 32'(pix_data), 32'h000F00);
        pix_ready = 1'b1;
        collect(RED4, 2'd0, "t5 late frame");
        wait_frame(1300, "t5 next frame");
        collect(RED4, 2'd0, "t5 f1300");

        // 6: asynchronous reset on word 2
        press();
        wait_frame(1400, "t6 f1400");
        step(2);
        check("t6 word2 data", 32'(pix_data), 32'h0F0000);
        check("t6 word2 mode", 32'(mode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async valid", 32'(pix_valid), 32'd0);
        check("t6 async last", 32'(pix_last), 32'd0);
        check("t6 async mode", 32'(mode), 32'd0);
        check("t6 async data", 32'(pix_data), 32'd0);
        step(2);
        rst_n = 1'b1;
        ecount = 0;
        wait_frame(100, "t6 after reset");
        collect(RED4, 2'd0, "t6 frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
